mc_ctrl: RTL

Multi-cycle control unit for the p4 single-issue MIPS-subset datapath. It is the issuing end of the ALU interface: it sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the 3-bit ALU opcode. It consumes the ALU ZERO flag for branches and generates every register, PC and memory write enable. It sits between the instruction register (IR) and the datapath muxes and registers.

---
 rtl/mc_ctrl.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle control unit for the p4 MIPS-subset datapath.
// Sequences FETCH/DECODE/EXEC/MEM/WB, drives the ALU opcode and every
// PC/IR/memory/register write enable. Outputs are decoded combinationally
// from the state register and the current IR contents.
module mc_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        zero,
  output logic [2:0]  state,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic [2:0]  alu_op,
  output logic        alu_b_sel,
  output logic        ext_op,
  output logic        aluout_we,
  output logic        mem_we,
  output logic        mdr_we,
  output logic        reg_we,
  output logic        reg_dst,
  output logic        wd_sel,
  output logic        done
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_JMP = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b010;
  localparam logic [2:0] ALU_CEQ = 3'b011;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  // One-hot-ish instruction class flags; all clear means illegal.
  typedef struct packed {
    logic addu;
    logic subu;
    logic ori;
    logic lw;
    logic sw;
    logic beq;
    logic j;
  } dec_t;

  state_t     st, st_nxt;
  dec_t       dec;
  logic       illegal;
  logic [5:0] opc, fn;

  // Register-number and immediate fields are datapath-only.
  logic unused_instr_bits;
  assign unused_instr_bits = ^instr[25:6];

  assign opc   = instr[31:26];
  assign fn    = instr[5:0];
  assign state = st;

  // Instruction class decode from opcode/funct.
  always_comb begin
    dec      = '0;
    dec.addu = (opc == OP_RTYPE) && (fn == FN_ADDU);
    dec.subu = (opc == OP_RTYPE) && (fn == FN_SUBU);
    dec.ori  = (opc == OP_ORI);
    dec.lw   = (opc == OP_LW);
    dec.sw   = (opc == OP_SW);
    dec.beq  = (opc == OP_BEQ);
    dec.j    = (opc == OP_J);
    illegal  = ~|dec;
  end

  // State register; reset aborts any in-flight instruction.
  always_ff @(posedge clk) begin
    if (reset) st <= S_FETCH;
    else       st <= st_nxt;
  end

  // Next-state and control outputs; reset masks every enable.
  always_comb begin
    st_nxt    = S_FETCH;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_src    = PC_SEQ;
    alu_op    = ALU_ADD;
    alu_b_sel = 1'b0;
    ext_op    = 1'b0;
    aluout_we = 1'b0;
    mem_we    = 1'b0;
    mdr_we    = 1'b0;
    reg_we    = 1'b0;
    reg_dst   = 1'b0;
    wd_sel    = 1'b0;
    done      = 1'b0;

    case (st)
      S_FETCH: begin
        ir_we  = 1'b1;
        pc_we  = 1'b1;
        pc_src = PC_SEQ;
        st_nxt = S_DECODE;
      end

      S_DECODE: begin
        if (dec.j) begin
          pc_we  = 1'b1;
          pc_src = PC_JMP;
          done   = 1'b1;
          st_nxt = S_FETCH;
        end else if (illegal) begin
          // Unknown encodings retire as a nop.
          done   = 1'b1;
          st_nxt = S_FETCH;
        end else begin
          st_nxt = S_EXEC;
        end
      end

      S_EXEC: begin
        if (dec.addu) begin
          aluout_we = 1'b1;
          alu_op    = ALU_ADD;
          st_nxt    = S_WB;
        end else if (dec.subu) begin
          aluout_we = 1'b1;
          alu_op    = ALU_SUB;
          st_nxt    = S_WB;
        end else if (dec.ori) begin
          aluout_we = 1'b1;
          alu_op    = ALU_OR;
          alu_b_sel = 1'b1;
          ext_op    = 1'b0;
          st_nxt    = S_WB;
        end else if (dec.lw || dec.sw) begin
          aluout_we = 1'b1;
          alu_op    = ALU_ADD;
          alu_b_sel = 1'b1;
          ext_op    = 1'b1;
          st_nxt    = S_MEM;
        end else if (dec.beq) begin
          // Branch resolves on the same-cycle ZERO flag; not taken keeps
          // the PC+4 already written in FETCH.
          aluout_we = 1'b1;
          alu_op    = ALU_CEQ;
          ext_op    = 1'b1;
          pc_src    = PC_BR;
          pc_we     = zero;
          done      = 1'b1;
          st_nxt    = S_FETCH;
        end else begin
          st_nxt = S_FETCH;
        end
      end

      S_MEM: begin
        if (dec.sw) begin
          mem_we = 1'b1;
          done   = 1'b1;
          st_nxt = S_FETCH;
        end else if (dec.lw) begin
          mdr_we = 1'b1;
          st_nxt = S_WB;
        end else begin
          st_nxt = S_FETCH;
        end
      end

      S_WB: begin
        reg_we  = 1'b1;
        done    = 1'b1;
        reg_dst = dec.addu | dec.subu;
        wd_sel  = dec.lw;
        st_nxt  = S_FETCH;
      end

      default: st_nxt = S_FETCH;
    endcase

    if (reset) begin
      ir_we     = 1'b0;
      pc_we     = 1'b0;
      pc_src    = PC_SEQ;
      alu_op    = ALU_ADD;
      alu_b_sel = 1'b0;
      ext_op    = 1'b0;
      aluout_we = 1'b0;
      mem_we    = 1'b0;
      mdr_we    = 1'b0;
      reg_we    = 1'b0;
      reg_dst   = 1'b0;
      wd_sel    = 1'b0;
      done      = 1'b0;
    end
  end

endmodule
